sync_fifo_v2: RTL and testbench
===============================

// Module: sync_fifo_v2
// PURPOSE
//   Parametrised single-clock FIFO, next generation of the basic sync FIFO.
//   Adds first-word-fall-through (FWFT) or standard read mode, occupancy count,
//   programmable almost-full/almost-empty flags, and sticky overflow/underflow
//   error flags. Used as the general-purpose buffer between pipeline stages
//   and bus front-ends that share one clock domain.
// PARAMETERS
//   DATA_WIDTH     8              word width in bits (>=1)
//   DEPTH          16             number of entries; power of two, >=2
//   ADDR_WIDTH     $clog2(DEPTH)  derived; do not override
//   FWFT           1'b0           1: head word shown on dout while !empty; 0: 1-cycle registered read
//   AFULL_THRESH   DEPTH-2        almost_full asserted when count >= AFULL_THRESH
//   AEMPTY_THRESH  2              almost_empty asserted when count <= AEMPTY_THRESH
// PORTS
//   clk           in   1             clock, all logic on rising edge
//   rst           in   1             synchronous reset, active-high
//   wr_en         in   1             write request
//   din           in   DATA_WIDTH    write data
//   full          out  1             count == DEPTH
//   almost_full   out  1             count >= AFULL_THRESH
//   rd_en         in   1             read request (FWFT: acknowledge/pop of head word)
//   dout          out  DATA_WIDTH    read data
//   rd_valid      out  1             dout holds valid data (see BEHAVIOUR)
//   empty         out  1             count == 0
//   almost_empty  out  1             count <= AEMPTY_THRESH
//   count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//   overflow      out  1             sticky: write attempted while full
//   underflow     out  1             sticky: read attempted while empty
//   clr_err       in   1             clears overflow/underflow
// BEHAVIOUR
//   - Reset (rst=1 at edge): pointers=0, count=0, empty=1, almost_empty=1, full=0,
//     almost_full=0 (if AFULL_THRESH>0), dout=0, rd_valid=0, overflow=0, underflow=0.
//     Reset mid-operation discards all contents; no write/read takes effect that cycle.
//   - Write accepted iff wr_en && !full; stores din at wr_ptr, wr_ptr wraps mod DEPTH.
//   - Read accepted iff rd_en && !empty; rd_ptr advances, wraps mod DEPTH.
//   - Flags are decided from pre-edge state only: write while full is rejected even
//     if a read is accepted the same cycle; read while empty is rejected even if a
//     write is accepted the same cycle.
//   - count: +1 on write only, -1 on read only, unchanged on both or neither.
//     full/empty/almost_* are combinational from registered count; they update in
//     the cycle following the accepting edge.
//   - Standard mode (FWFT=0): on accepted read, dout <= mem[rd_ptr] and rd_valid=1
//     for exactly the next cycle; otherwise rd_valid=0 and dout holds last value.
//   - FWFT mode: rd_valid = !empty; dout = mem[rd_ptr] (head word) whenever
//     rd_valid=1; first word written into empty FIFO visible on dout in the cycle
//     after the write edge. rd_en pops head; next word visible the following cycle.
//     dout is don't-care while empty.
//   - overflow set on wr_en && full; underflow set on rd_en && empty; both hold until
//     clr_err or rst. If clr_err and a new error coincide, the flag stays set.
//   - Full capacity is exactly DEPTH entries in both modes.
// TESTING
//   1. rst, then 16 writes 0x00..0x0F (DEPTH=16) -> full=1, count=16, almost_full
//      set at count=14, overflow=0; 17th write -> overflow=1, contents unchanged.
//   2. Drain 16 reads (FWFT=0) -> dout 0x00..0x0F in order, rd_valid one cycle after
//      each rd_en, then empty=1; extra rd_en -> underflow=1, rd_valid stays 0.
//   3. FWFT=1: write 0xA5 into empty FIFO -> next cycle rd_valid=1, dout=0xA5 with no
//      rd_en; rd_en pops -> empty=1, count=0.
//   4. At count=8, wr_en=rd_en=1 for 40 cycles with incrementing data -> count stays 8,
//      pointers wrap twice, output order matches input order with no loss.
//   5. Full FIFO, wr_en=rd_en=1 -> read accepted, write rejected, count=15, overflow=1;
//      empty FIFO, both -> write accepted, read rejected, count=1, underflow=1.
//   6. rst asserted with count=9 and overflow=1 -> next cycle count=0, empty=1,
//      overflow=0, rd_valid=0; clr_err with wr_en&&full same cycle keeps overflow=1.

Source files
------------

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO with selectable standard/FWFT read mode,
// occupancy count, almost-full/almost-empty flags and sticky error flags.
module sync_fifo_v2 #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status flags come from the registered count only, so they lag the accepting edge by one cycle.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance uses pre-edge full/empty: a same-cycle pop never makes room for a push, and vice versa.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (wr_acc && !rd_acc)      count_q <= count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_q <= count_q - CW'(1);
    end
  end

  // Storage array; left unreset because contents are only observable through the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= din;
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full)  overflow_q <= 1'b1;
      else if (clr_err)   overflow_q <= 1'b0;
      if (rd_en && empty) underflow_q <= 1'b1;
      else if (clr_err)   underflow_q <= 1'b0;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented combinationally; zero while empty keeps dout defined after reset.
    assign rd_valid = !empty;
    assign dout     = empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rd_valid_q;

    // Registered read: data lands one cycle after the accepted rd_en and then holds.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr];
      end
    end

    assign rd_valid = rd_valid_q;
    assign dout     = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: one standard-mode and one FWFT instance share stimulus.
module tb_sync_fifo_v2;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, clr_err;
  logic [7:0] din;

  logic       s_full, s_afull, s_empty, s_aempty, s_valid, s_ovf, s_udf;
  logic [7:0] s_dout;
  logic [4:0] s_count;
  logic       f_full, f_afull, f_empty, f_aempty, f_valid, f_ovf, f_udf;
  logic [7:0] f_dout;
  logic [4:0] f_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(s_full),
    .almost_full(s_afull), .rd_en(rd_en), .dout(s_dout), .rd_valid(s_valid),
    .empty(s_empty), .almost_empty(s_aempty), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err));

  sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(f_full),
    .almost_full(f_afull), .rd_en(rd_en), .dout(f_dout), .rd_valid(f_valid),
    .empty(f_empty), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err));

  typedef struct {
    int rst, wr, din, rd, clr;
    int cnt, full, afull, empty, aempty, ovf, udf, sval, sdout, fval, fdout;
  } vec_t;

  vec_t tbl[14];

  // reference model state for the hand-written sequences
  int mq[$];
  int movf, mudf, msval, msdout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int r, input int w, input int d, input int rd, input int c);
    rst     = r[0];
    wr_en   = w[0];
    din     = d[7:0];
    rd_en   = rd[0];
    clr_err = c[0];
  endtask

  task automatic step(input int r, input int w, input int d, input int rd, input int c);
    int sz;
    bit wacc, racc;
    drive(r, w, d, rd, c);
    sz   = mq.size();
    wacc = (w != 0) && (sz < 16);
    racc = (rd != 0) && (sz > 0);
    if (r != 0) begin
      mq.delete();
      movf = 0; mudf = 0; msval = 0; msdout = 0;
    end else begin
      if (w != 0 && sz == 16) movf = 1; else if (c != 0) movf = 0;
      if (rd != 0 && sz == 0) mudf = 1; else if (c != 0) mudf = 0;
      if (racc) begin
        msdout = mq.pop_front();
        msval  = 1;
      end else begin
        msval = 0;
      end
      if (wacc) mq.push_back(d & 8'hFF);
    end
    @(posedge clk);
    #1;
    sz = mq.size();
    chk("count",        32'(s_count),  32'(sz));
    chk("fwft_count",   32'(f_count),  32'(sz));
    chk("full",         32'(s_full),   32'(sz == 16));
    chk("almost_full",  32'(s_afull),  32'(sz >= 14));
    chk("empty",        32'(s_empty),  32'(sz == 0));
    chk("almost_empty", 32'(s_aempty), 32'(sz <= 2));
    chk("overflow",     32'(s_ovf),    32'(movf));
    chk("underflow",    32'(s_udf),    32'(mudf));
    chk("fwft_overflow",32'(f_ovf),    32'(movf));
    chk("std_rd_valid", 32'(s_valid),  32'(msval));
    chk("std_dout",     32'(s_dout),   32'(msdout));
    chk("fwft_rd_valid",32'(f_valid),  32'(sz > 0));
    if (sz > 0) chk("fwft_dout", 32'(f_dout), 32'(mq[0]));
  endtask

  initial begin
    //          rst wr din    rd clr | cnt full af emp ae ovf udf sval sdout fval fdout
    tbl[0]  = '{1,  0, 'h00,  0, 0,    0,  0,   0, 1,  1, 0,  0,  0,   'h00, 0,   'h00};
    tbl[1]  = '{0,  0, 'h00,  1, 0,    0,  0,   0, 1,  1, 0,  1,  0,   'h00, 0,   'h00};
    tbl[2]  = '{0,  1, 'hA5,  0, 1,    1,  0,   0, 0,  1, 0,  0,  0,   'h00, 1,   'hA5};
    tbl[3]  = '{0,  0, 'h00,  0, 0,    1,  0,   0, 0,  1, 0,  0,  0,   'h00, 1,   'hA5};
    tbl[4]  = '{0,  0, 'h00,  1, 0,    0,  0,   0, 1,  1, 0,  0,  1,   'hA5, 0,   'h00};
    tbl[5]  = '{0,  0, 'h00,  0, 0,    0,  0,   0, 1,  1, 0,  0,  0,   'hA5, 0,   'h00};
    tbl[6]  = '{0,  1, 'h11,  1, 0,    1,  0,   0, 0,  1, 0,  1,  0,   'hA5, 1,   'h11};
    tbl[7]  = '{0,  1, 'h22,  0, 1,    2,  0,   0, 0,  1, 0,  0,  0,   'hA5, 1,   'h11};
    tbl[8]  = '{0,  1, 'h33,  0, 0,    3,  0,   0, 0,  0, 0,  0,  0,   'hA5, 1,   'h11};
    tbl[9]  = '{0,  1, 'h44,  1, 0,    3,  0,   0, 0,  0, 0,  0,  1,   'h11, 1,   'h22};
    tbl[10] = '{0,  0, 'h00,  1, 0,    2,  0,   0, 0,  1, 0,  0,  1,   'h22, 1,   'h33};
    tbl[11] = '{1,  0, 'h00,  1, 0,    0,  0,   0, 1,  1, 0,  0,  0,   'h00, 0,   'h00};
    tbl[12] = '{0,  0, 'h00,  1, 1,    0,  0,   0, 1,  1, 0,  1,  0,   'h00, 0,   'h00};
    tbl[13] = '{0,  0, 'h00,  0, 1,    0,  0,   0, 1,  1, 0,  0,  0,   'h00, 0,   'h00};

    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].clr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i),        32'(s_count),  32'(tbl[i].cnt));
      chk($sformatf("v%0d_fwft_count", i),   32'(f_count),  32'(tbl[i].cnt));
      chk($sformatf("v%0d_full", i),         32'(s_full),   32'(tbl[i].full));
      chk($sformatf("v%0d_almost_full", i),  32'(s_afull),  32'(tbl[i].afull));
      chk($sformatf("v%0d_empty", i),        32'(s_empty),  32'(tbl[i].empty));
      chk($sformatf("v%0d_almost_empty", i), 32'(s_aempty), 32'(tbl[i].aempty));
      chk($sformatf("v%0d_overflow", i),     32'(s_ovf),    32'(tbl[i].ovf));
      chk($sformatf("v%0d_underflow", i),    32'(s_udf),    32'(tbl[i].udf));
      chk($sformatf("v%0d_fwft_underflow", i), 32'(f_udf),  32'(tbl[i].udf));
      chk($sformatf("v%0d_std_rd_valid", i), 32'(s_valid),  32'(tbl[i].sval));
      chk($sformatf("v%0d_std_dout", i),     32'(s_dout),   32'(tbl[i].sdout));
      chk($sformatf("v%0d_fwft_rd_valid", i),32'(f_valid),  32'(tbl[i].fval));
      if (tbl[i].fval != 0)
        chk($sformatf("v%0d_fwft_dout", i),  32'(f_dout),   32'(tbl[i].fdout));
    end

    // table ends in a clean post-reset state
    mq.delete();
    movf = 0; mudf = 0; msval = 0; msdout = 0;

    // fill to capacity, then overflow attempt
    for (int i = 0; i < 16; i++) step(0, 1, i, 0, 0);
    step(0, 1, 'hEE, 0, 0);
    step(0, 0, 0, 0, 1);
    // full with both requests: pop only, write rejected, overflow set
    step(0, 1, 'hEE, 1, 0);
    chk("full_both_count", 32'(s_count), 32'd15);
    chk("full_both_ovf", 32'(s_ovf), 32'd1);
    step(0, 1, 'h10, 0, 0);
    // clear coinciding with a new overflow keeps the flag
    step(0, 1, 'h77, 0, 1);
    chk("clr_vs_new_ovf", 32'(s_ovf), 32'd1);
    // drain, then underflow attempt
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("drain_extra_valid", 32'(s_valid), 32'd0);
    // empty with both requests: push only
    step(0, 1, 'h99, 1, 0);
    chk("empty_both_count", 32'(s_count), 32'd1);
    step(0, 0, 0, 1, 0);

    // steady-state streaming at count 8, pointers wrap
    for (int i = 0; i < 8; i++) step(0, 1, 'h20 + i, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 'h30 + i, 1, 0);
    chk("stream_count", 32'(s_count), 32'd8);

    // reset mid-operation with count 9 and overflow still set
    step(0, 1, 'hC0, 0, 0);
    chk("pre_rst_count", 32'(s_count), 32'd9);
    chk("pre_rst_ovf", 32'(s_ovf), 32'd1);
    step(1, 1, 'hC1, 1, 0);
    step(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
